// File: rtl/lk_window_sequencer_if.sv
//----------------------------------------------------------------------------
// lk_window_sequencer_if
//
// Purpose: bundles every signal between the window sequencer and the rest
// of the system. This includes the pixel/frame-load side, the
// feature-point handshake, the window-read beat bus to the line-buffer
// memory and the status flags.
//
// Modports:
//   master - the sequencer itself (drives write/read addresses, pt_ready,
//            status pulses)
//   slave  - the surrounding system (pixel source, feature-point queue,
//            gradient/Hessian datapath)
//
// Signals:
//   frame_start, pix_valid      slave -> master  frame-load control
//   wr_en, wr_addr, frame_ready master -> slave  memory write port / status
//   pt_valid, pt_row, pt_col    slave -> master  feature point offer
//   pt_ready                    master -> slave  point accept
//   rd_ready                    slave -> master  downstream beat accept
//   rd_en, rd_addr0..2,
//   lane_mask, rd_last          master -> slave  window read beat
//   win_done, err_oob, busy     master -> slave  status pulses / level
//----------------------------------------------------------------------------
interface lk_window_sequencer_if #(
  parameter int ADDR_W = 11,
  parameter int RC_W   = 6
);

  logic              frame_start;
  logic              pix_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              frame_ready;

  logic              pt_valid;
  logic              pt_ready;
  logic [RC_W-1:0]   pt_row;
  logic [RC_W-1:0]   pt_col;

  logic              rd_en;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr0;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [2:0]        lane_mask;
  logic              rd_last;
  logic              win_done;

  logic              err_oob;
  logic              busy;

  modport master (
    input  frame_start, pix_valid, pt_valid, pt_row, pt_col, rd_ready,
    output wr_en, wr_addr, frame_ready, pt_ready, rd_en,
           rd_addr0, rd_addr1, rd_addr2, lane_mask, rd_last,
           win_done, err_oob, busy
  );

  modport slave (
    output frame_start, pix_valid, pt_valid, pt_row, pt_col, rd_ready,
    input  wr_en, wr_addr, frame_ready, pt_ready, rd_en,
           rd_addr0, rd_addr1, rd_addr2, lane_mask, rd_last,
           win_done, err_oob, busy
  );

endinterface

// File: rtl/lk_window_sequencer.sv
//----------------------------------------------------------------------------
// lk_window_sequencer
//
// Purpose: controller for the pyramidal-LK line-buffer window memory.
// The controller works in two phases.
//   1. Frame load: it generates linear write addresses for ROWS*COLS pixels.
//   2. Read: for each accepted feature point (row,col) it walks the
//      WIN x WIN window around that point. Each beat reads LANES rows of a
//      single column. The window is covered in strips of LANES rows, left
//      to right within a strip.
//
// Ports:
//   clk     in  clock
//   rst     in  asynchronous, active-high reset (returns to IDLE)
//   io_bus  master modport of lk_window_sequencer_if
//           (frame load, point handshake, read beats, status)
//----------------------------------------------------------------------------
module lk_window_sequencer #(
  parameter int COLS   = 33,
  parameter int ROWS   = 33,
  parameter int WIN    = 7,
  parameter int LANES  = 3,
  parameter int ADDR_W = $clog2(ROWS * COLS),
  parameter int RC_W   = $clog2((ROWS > COLS) ? ROWS : COLS)
) (
  input  logic                   clk,
  input  logic                   rst,
  lk_window_sequencer_if.master  io_bus
);

  localparam int HALF   = WIN / 2;
  localparam int STRIPS = (WIN + LANES - 1) / LANES;
  localparam int S_W    = $clog2(STRIPS + 1);
  localparam int C_W    = $clog2(WIN);

  localparam logic [ADDR_W-1:0] LAST_WR   = ADDR_W'(ROWS * COLS - 1);
  localparam logic [ADDR_W-1:0] A_HALF    = ADDR_W'(HALF);
  localparam logic [ADDR_W-1:0] A_COLS    = ADDR_W'(COLS);
  // Jump from the last column of one strip to the first column of the next.
  localparam logic [ADDR_W-1:0] A_STRIPJMP = ADDR_W'(LANES * COLS - (WIN - 1));
  localparam logic [RC_W-1:0]   RC_LO     = RC_W'(HALF);
  localparam logic [RC_W-1:0]   ROW_HI    = RC_W'(ROWS - 1 - HALF);
  localparam logic [RC_W-1:0]   COL_HI    = RC_W'(COLS - 1 - HALF);
  localparam logic [C_W-1:0]    C_LAST    = C_W'(WIN - 1);
  localparam logic [S_W-1:0]    S_LAST    = S_W'(STRIPS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_PT,
    S_CALC,
    S_READ
  } state_t;

  state_t            r_state;
  state_t            w_nextState;

  logic [ADDR_W-1:0] r_wrAddr;
  logic              r_frameReady;
  logic [RC_W-1:0]   r_row;
  logic [RC_W-1:0]   r_col;
  logic [S_W-1:0]    r_s;
  logic [C_W-1:0]    r_c;
  logic [ADDR_W-1:0] r_rdAddr [LANES];
  logic              r_winDone;

  logic              w_wrEn;
  logic              w_ptReady;
  logic              w_rdEn;
  logic              w_errOob;
  logic              w_busy;
  logic              w_restart;
  logic              w_lastWrite;
  logic              w_ptAccept;
  logic              w_beat;
  logic              w_lastBeat;
  logic              w_lastPos;
  logic              w_legal;
  logic [ADDR_W-1:0] w_base;
  logic [2:0]        w_laneMask;
  logic              w_rdLast;

  // Window position checks and the top-left address of the window. The
  // base is only used when the point is legal, so the subtractions never
  // underflow.
  assign w_lastPos = (r_s == S_LAST) && (r_c == C_LAST);
  assign w_legal   = (r_row >= RC_LO) && (r_row <= ROW_HI) &&
                     (r_col >= RC_LO) && (r_col <= COL_HI);
  assign w_base    = (ADDR_W'(r_row) - A_HALF) * A_COLS + ADDR_W'(r_col) - A_HALF;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and per-state control strobes. In IDLE, LOAD and
  // WAIT_PT, frame_start takes priority over any other activity. While a
  // point is being processed (CALC/READ), frame_start is ignored.
  always_comb begin
    w_nextState = r_state;
    w_wrEn      = 1'b0;
    w_ptReady   = 1'b0;
    w_rdEn      = 1'b0;
    w_errOob    = 1'b0;
    w_busy      = 1'b0;
    w_restart   = 1'b0;
    w_lastWrite = 1'b0;
    w_ptAccept  = 1'b0;
    w_beat      = 1'b0;
    w_lastBeat  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.frame_start) begin
          w_restart   = 1'b1;
          w_nextState = S_LOAD;
        end
      end
      S_LOAD: begin
        w_busy = 1'b1;
        w_wrEn = io_bus.pix_valid;
        if (io_bus.frame_start) begin
          w_restart = 1'b1;
        end else if (io_bus.pix_valid && (r_wrAddr == LAST_WR)) begin
          w_lastWrite = 1'b1;
          w_nextState = S_WAIT_PT;
        end
      end
      S_WAIT_PT: begin
        if (io_bus.frame_start) begin
          w_restart   = 1'b1;
          w_nextState = S_LOAD;
        end else begin
          w_ptReady = 1'b1;
          if (io_bus.pt_valid) begin
            w_ptAccept  = 1'b1;
            w_nextState = S_CALC;
          end
        end
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (w_legal) begin
          w_nextState = S_READ;
        end else begin
          w_errOob    = 1'b1;
          w_nextState = S_WAIT_PT;
        end
      end
      S_READ: begin
        w_busy = 1'b1;
        w_rdEn = 1'b1;
        if (io_bus.rd_ready) begin
          w_beat = 1'b1;
          if (w_lastPos) begin
            w_lastBeat  = 1'b1;
            w_nextState = S_WAIT_PT;
          end
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Frame-load address counter and the frame_ready flag. On the final
  // write the counter holds its value instead of stepping past the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrAddr     <= '0;
      r_frameReady <= 1'b0;
    end else if (w_restart) begin
      r_wrAddr     <= '0;
      r_frameReady <= 1'b0;
    end else if (w_wrEn) begin
      if (w_lastWrite) begin
        r_frameReady <= 1'b1;
      end else begin
        r_wrAddr <= r_wrAddr + ADDR_W'(1);
      end
    end
  end

  // Capture the feature point when it is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_ptAccept) begin
      r_row <= io_bus.pt_row;
      r_col <= io_bus.pt_col;
    end
  end

  // Window walker. CALC loads the first column of strip 0. Each consumed
  // beat then either steps one column right or jumps to the start of the
  // next strip. The lane addresses are updated incrementally, so no
  // multiplier sits in the beat path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s <= '0;
      r_c <= '0;
      for (int k = 0; k < LANES; k++) begin
        r_rdAddr[k] <= '0;
      end
    end else if ((r_state == S_CALC) && w_legal) begin
      r_s <= '0;
      r_c <= '0;
      for (int k = 0; k < LANES; k++) begin
        r_rdAddr[k] <= w_base + ADDR_W'(k * COLS);
      end
    end else if (w_beat) begin
      if (r_c == C_LAST) begin
        r_c <= '0;
        r_s <= r_s + S_W'(1);
        for (int k = 0; k < LANES; k++) begin
          r_rdAddr[k] <= r_rdAddr[k] + A_STRIPJMP;
        end
      end else begin
        r_c <= r_c + C_W'(1);
        for (int k = 0; k < LANES; k++) begin
          r_rdAddr[k] <= r_rdAddr[k] + ADDR_W'(1);
        end
      end
    end
  end

  // win_done fires the cycle after the final beat is consumed. Because it
  // is a register, a reset in mid-window simply discards it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_winDone <= 1'b0;
    end else begin
      r_winDone <= w_lastBeat;
    end
  end

  // A lane is valid while its window row is still inside the window. Only
  // the last strip can have lanes that fall past row WIN-1.
  always_comb begin
    w_laneMask = '0;
    w_rdLast   = 1'b0;
    if (r_state == S_READ) begin
      for (int k = 0; k < LANES; k++) begin
        w_laneMask[k] = ((int'(r_s) * LANES) + k) < WIN;
      end
      w_rdLast = w_lastPos;
    end
  end

  assign io_bus.wr_en       = w_wrEn;
  assign io_bus.wr_addr     = r_wrAddr;
  assign io_bus.frame_ready = r_frameReady;
  assign io_bus.pt_ready    = w_ptReady;
  assign io_bus.rd_en       = w_rdEn;
  assign io_bus.rd_addr0    = r_rdAddr[0];
  assign io_bus.rd_addr1    = r_rdAddr[1];
  assign io_bus.rd_addr2    = r_rdAddr[2];
  assign io_bus.lane_mask   = w_laneMask;
  assign io_bus.rd_last     = w_rdLast;
  assign io_bus.win_done    = r_winDone;
  assign io_bus.err_oob     = w_errOob;
  assign io_bus.busy        = w_busy;

endmodule

// File: tb/tb_lk_window_sequencer.sv
//----------------------------------------------------------------------------
// tb_lk_window_sequencer
//
// Purpose: self-checking bench for lk_window_sequencer (33x33 frame, 7x7
// window). The expected read beats for a point come from a reference model
// that enumerates the window directly from (row, col): rows row-HALF+r and
// columns col-HALF+c, grouped in strips of three rows. The model also
// reports which points are legal. A table of points gives fixed expected
// first/last addresses. Hand-written sequences cover frame load,
// back-pressure, the frame_start/pt_valid collision and reset during a
// read. Inputs are driven 1 time unit after the rising edge, and outputs
// are sampled on the falling edge.
//----------------------------------------------------------------------------
module tb_lk_window_sequencer;

  localparam int COLS   = 33;
  localparam int ROWS   = 33;
  localparam int WIN    = 7;
  localparam int LANES  = 3;
  localparam int HALF   = WIN / 2;
  localparam int STRIPS = (WIN + LANES - 1) / LANES;
  localparam int NPIX   = ROWS * COLS;
  localparam int ADDR_W = 11;
  localparam int RC_W   = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  lk_window_sequencer_if #(.ADDR_W(ADDR_W), .RC_W(RC_W)) bus ();

  lk_window_sequencer #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .WIN   (WIN),
    .LANES (LANES),
    .ADDR_W(ADDR_W),
    .RC_W  (RC_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  typedef struct {
    int a0;
    int a1;
    int a2;
    int mask;
    bit last;
  } beat_t;

  typedef struct {
    int row;
    int col;
    bit expOob;
    int expBeats;
    int expFirst;
    int expLast;
  } vec_t;

  beat_t expQ[$];
  vec_t  vecs[8];
  int    nChecks = 0;
  int    nPass   = 0;

  // Count one comparison and report it if the values differ.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) begin
      nPass++;
    end else begin
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Every DUT output packed together; it must be all zero in IDLE/reset.
  function automatic logic [63:0] allOut();
    return 64'({bus.wr_en, bus.wr_addr, bus.frame_ready, bus.pt_ready, bus.rd_en,
                bus.rd_addr0, bus.rd_addr1, bus.rd_addr2, bus.lane_mask,
                bus.rd_last, bus.win_done, bus.err_oob, bus.busy});
  endfunction

  // A point is legal when the whole window lies inside the frame.
  function automatic bit isLegal(input int r, input int c);
    return (r - HALF >= 0) && (r + HALF <= ROWS - 1) &&
           (c - HALF >= 0) && (c + HALF <= COLS - 1);
  endfunction

  // List every beat of the window around (r,c) in the order it is read.
  task automatic buildWindow(input int r, input int c);
    beat_t b;
    int    wr;
    expQ.delete();
    for (int s = 0; s < STRIPS; s++) begin
      for (int col = 0; col < WIN; col++) begin
        wr     = s * LANES;
        b.a0   = ((r - HALF + wr)     * COLS + (c - HALF + col)) % (1 << ADDR_W);
        b.a1   = ((r - HALF + wr + 1) * COLS + (c - HALF + col)) % (1 << ADDR_W);
        b.a2   = ((r - HALF + wr + 2) * COLS + (c - HALF + col)) % (1 << ADDR_W);
        b.mask = ((wr < WIN) ? 1 : 0) + ((wr + 1 < WIN) ? 2 : 0) + ((wr + 2 < WIN) ? 4 : 0);
        b.last = (s == STRIPS - 1) && (col == WIN - 1);
        expQ.push_back(b);
      end
    end
  endtask

  // Load a full frame with random pix_valid gaps. This checks every write
  // address and the rise of frame_ready.
  task automatic loadFrame(input bit doStart);
    int expAddr;
    int cyc;
    if (doStart) begin
      bus.frame_start = 1'b1;
      @(posedge clk); #1;
      bus.frame_start = 1'b0;
    end
    expAddr = 0;
    cyc     = 0;
    while (expAddr < NPIX && cyc < 8000) begin
      bus.pix_valid = ($urandom_range(3) != 0);
      @(negedge clk);
      checkOutput("load wr_en", bus.wr_en, bus.pix_valid);
      checkOutput("load pt_ready", bus.pt_ready, 0);
      checkOutput("load frame_ready", bus.frame_ready, 0);
      checkOutput("load busy", bus.busy, 1);
      if (bus.pix_valid) begin
        checkOutput("load wr_addr", bus.wr_addr, expAddr);
        expAddr++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.pix_valid = 1'b0;
    checkOutput("load completed", expAddr, NPIX);
    @(negedge clk);
    checkOutput("frame_ready rise", bus.frame_ready, 1);
    checkOutput("pt_ready after load", bus.pt_ready, 1);
    checkOutput("busy after load", bus.busy, 0);
    @(posedge clk); #1;
  endtask

  // Offer one point and follow it to completion, checking every beat
  // against the model. rd_ready is randomly low stallPct% of the time. It
  // is also forced low for stallLen cycles when beat index stallBeat is
  // presented.
  task automatic applyStimulus(input int row, input int col, input int stallPct,
                               input int stallBeat, input int stallLen,
                               output int beats, output int firstA0,
                               output int lastA0, output bit oobSeen);
    int    cyc;
    int    lastBeatCyc;
    int    winCyc;
    int    stallLeft;
    bit    done;
    beat_t b;
    beats       = 0;
    firstA0     = -1;
    lastA0      = -1;
    oobSeen     = 1'b0;
    lastBeatCyc = -10;
    winCyc      = -1;
    stallLeft   = stallLen;
    done        = 1'b0;
    buildWindow(row, col);

    bus.pt_valid = 1'b1;
    bus.pt_row   = RC_W'(row);
    bus.pt_col   = RC_W'(col);
    bus.rd_ready = 1'b1;
    @(negedge clk);
    checkOutput("pt_ready on offer", bus.pt_ready, 1);
    checkOutput("win_done single pulse", bus.win_done, 0);
    @(posedge clk); #1;
    bus.pt_valid = 1'b0;

    @(negedge clk);
    oobSeen = bus.err_oob;
    checkOutput("calc rd_en", bus.rd_en, 0);
    checkOutput("calc busy", bus.busy, 1);
    @(posedge clk); #1;

    if (!isLegal(row, col)) begin
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        checkOutput("oob rd_en", bus.rd_en, 0);
        checkOutput("oob err_oob width", bus.err_oob, 0);
        checkOutput("oob pt_ready", bus.pt_ready, 1);
        @(posedge clk); #1;
      end
      return;
    end

    cyc = 0;
    while (!done && cyc < 400) begin
      if (beats == stallBeat && stallLeft > 0) begin
        bus.rd_ready = 1'b0;
        stallLeft--;
      end else begin
        bus.rd_ready = ($urandom_range(99) >= stallPct);
      end
      @(negedge clk);
      if (cyc == 0) checkOutput("first beat latency", bus.rd_en, 1);
      if (bus.win_done) begin
        done   = 1'b1;
        winCyc = cyc;
        checkOutput("rd_en after window", bus.rd_en, 0);
        checkOutput("pt_ready after window", bus.pt_ready, 1);
      end else if (bus.rd_en) begin
        if (beats < expQ.size()) begin
          b = expQ[beats];
          checkOutput("rd_addr0", bus.rd_addr0, b.a0);
          checkOutput("rd_addr1", bus.rd_addr1, b.a1);
          checkOutput("rd_addr2", bus.rd_addr2, b.a2);
          checkOutput("lane_mask", bus.lane_mask, b.mask);
          checkOutput("rd_last", bus.rd_last, b.last);
        end else begin
          checkOutput("beat overrun", beats, expQ.size());
          done = 1'b1;
        end
        if (beats == 0) firstA0 = int'(bus.rd_addr0);
        if (bus.rd_last) lastA0 = int'(bus.rd_addr0);
        if (bus.rd_ready) begin
          beats++;
          lastBeatCyc = cyc;
        end
      end else begin
        checkOutput("rd_en during window", bus.rd_en, 1);
        done = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.rd_ready = 1'b0;
    checkOutput("win_done seen", done, 1);
    checkOutput("win_done latency", winCyc, lastBeatCyc + 1);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got time limit reached, expected run finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int beats;
    int firstA0;
    int lastA0;
    bit oob;
    int r;
    int c;

    vecs[0] = '{16, 16, 1'b0, 21, 442, 646};
    vecs[1] = '{ 2, 16, 1'b1,  0,   0,   0};
    vecs[2] = '{16, 30, 1'b1,  0,   0,   0};
    vecs[3] = '{ 3,  3, 1'b0, 21,   0, 204};
    vecs[4] = '{29, 29, 1'b0, 21, 884, 1088};
    vecs[5] = '{30, 16, 1'b1,  0,   0,   0};
    vecs[6] = '{16,  2, 1'b1,  0,   0,   0};
    vecs[7] = '{10, 20, 1'b0, 21, 248, 452};

    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.pt_valid    = 1'b0;
    bus.pt_row      = '0;
    bus.pt_col      = '0;
    bus.rd_ready    = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("outputs in reset", allOut(), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("idle after reset", allOut(), 0);
    @(posedge clk); #1;

    // Frame load with gaps
    loadFrame(1'b1);

    // Table of points at full rate
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].row, vecs[i].col, 0, -1, 0, beats, firstA0, lastA0, oob);
      checkOutput($sformatf("vec%0d err_oob", i), oob, vecs[i].expOob);
      if (!vecs[i].expOob) begin
        checkOutput($sformatf("vec%0d beats", i), beats, vecs[i].expBeats);
        checkOutput($sformatf("vec%0d first addr0", i), firstA0, vecs[i].expFirst);
        checkOutput($sformatf("vec%0d last addr0", i), lastA0, vecs[i].expLast);
      end
    end

    // Back-pressure: hold beat 5 (addr0 446) for 3 cycles
    applyStimulus(16, 16, 0, 4, 3, beats, firstA0, lastA0, oob);
    checkOutput("stall beats", beats, 21);
    checkOutput("stall last addr0", lastA0, 646);

    // Random points with random rd_ready
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(ROWS - 1);
      c = $urandom_range(COLS - 1);
      applyStimulus(r, c, 30, -1, 0, beats, firstA0, lastA0, oob);
      checkOutput($sformatf("rand(%0d,%0d) err_oob", r, c), oob, !isLegal(r, c));
      if (isLegal(r, c)) begin
        checkOutput($sformatf("rand(%0d,%0d) beats", r, c), beats, STRIPS * WIN);
        checkOutput($sformatf("rand(%0d,%0d) first", r, c), firstA0, (r - HALF) * COLS + (c - HALF));
      end
    end

    // Collision: frame_start beats pt_valid
    bus.frame_start = 1'b1;
    bus.pt_valid    = 1'b1;
    bus.pt_row      = RC_W'(16);
    bus.pt_col      = RC_W'(16);
    @(negedge clk);
    checkOutput("collision frame_ready before", bus.frame_ready, 1);
    checkOutput("collision pt_ready", bus.pt_ready, 0);
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    bus.pt_valid    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("collision busy", bus.busy, 1);
      checkOutput("collision rd_en", bus.rd_en, 0);
      checkOutput("collision err_oob", bus.err_oob, 0);
      checkOutput("collision frame_ready", bus.frame_ready, 0);
      checkOutput("collision wr_addr", bus.wr_addr, 0);
      @(posedge clk); #1;
    end
    loadFrame(1'b0);

    // Reset during beat 10 of a window
    bus.pt_valid = 1'b1;
    bus.pt_row   = RC_W'(16);
    bus.pt_col   = RC_W'(16);
    bus.rd_ready = 1'b1;
    @(posedge clk); #1;
    bus.pt_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("beat10 rd_en", bus.rd_en, 1);
    checkOutput("beat10 rd_addr0", bus.rd_addr0, 543);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset outputs", allOut(), 0);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("post-reset quiet", allOut(), 0);
      @(posedge clk); #1;
    end
    bus.rd_ready    = 1'b0;
    bus.frame_start = 1'b1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b1;
    @(negedge clk);
    checkOutput("restart wr_en", bus.wr_en, 1);
    checkOutput("restart wr_addr", bus.wr_addr, 0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("restart wr_addr step", bus.wr_addr, 1);
    @(posedge clk); #1;
    bus.pix_valid = 1'b0;

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/lk_window_sequencer.md
Name: lk_window_sequencer

Overview:
- Controller for the pyramidal-LK line-buffer window memory.
- Sequences two phases: a frame-load phase, which generates linear write addresses for ROWS*COLS pixels, and a per-feature-point read phase.
- In the read phase, each accepted center (row,col) is converted to a WIN x WIN window, read LANES rows at a time, one column per beat.
- Sits between the feature-point queue and the gradient/Hessian datapath, and drives the memory's write and read address ports.

Parameters:
- COLS, 33, image width in pixels
- ROWS, 33, image height in pixels
- WIN, 7, window side length (odd, 3..15)
- LANES, 3, rows read per beat (fixed at 3)
- ADDR_W, $clog2(ROWS*COLS), memory address width
- RC_W, $clog2(ROWS>COLS?ROWS:COLS), coordinate width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- frame_start  in  1  pulse: begin loading a new frame
- pix_valid  in  1  incoming pixel present this cycle
- wr_en  out  1  memory write strobe, equal to pix_valid while in LOAD
- wr_addr  out  ADDR_W  linear write address
- frame_ready  out  1  high once a complete frame is stored; cleared by frame_start
- pt_valid  in  1  feature point offered
- pt_ready  out  1  point accepted when pt_valid&pt_ready
- pt_row  in  RC_W  center row
- pt_col  in  RC_W  center column
- rd_en  out  1  read beat issued (rd_en&rd_ready = beat consumed)
- rd_ready  in  1  downstream can accept a beat
- rd_addr0, rd_addr1, rd_addr2  out  ADDR_W each  lane addresses
- lane_mask  out  3  valid lanes for this beat
- rd_last  out  1  final beat of the window
- win_done  out  1  one-cycle pulse after the last beat is consumed
- err_oob  out  1  one-cycle pulse when a point is rejected
- busy  out  1  high in LOAD, CALC and READ

Behaviour:
- Reset state: IDLE. All outputs are 0, all counters are 0, frame_ready=0.
- Derived constants: HALF=WIN/2, STRIPS=ceil(WIN/LANES).
- State IDLE:
  - frame_start -> LOAD.
  - pt_ready=0.
- State LOAD:
  - wr_addr starts at 0 and increments by 1 on every cycle with pix_valid.
  - wr_en=pix_valid (combinational).
  - When the write at address ROWS*COLS-1 occurs: next state WAIT_PT, frame_ready<=1 on the following edge.
  - pt_ready=0 throughout LOAD.
  - A second frame_start while in LOAD restarts the load: wr_addr returns to 0.
- State WAIT_PT:
  - pt_ready=1.
  - On handshake, the point is registered and the state moves to CALC.
  - frame_start in WAIT_PT -> LOAD and clears frame_ready. If frame_start and pt_valid occur in the same cycle, frame_start wins and the point is not accepted (pt_ready forced to 0 that cycle).
- State CALC (exactly 1 cycle):
  - The point is legal iff HALF<=row<=ROWS-1-HALF and HALF<=col<=COLS-1-HALF.
  - Illegal point: err_oob pulses in CALC and the state returns to WAIT_PT; no rd_en is ever asserted for that point.
  - Legal point: base = (row-HALF)*COLS + (col-HALF) is computed at ADDR_W width with no wrap. Strip s=0, column c=0. Next state READ.
- State READ:
  - rd_en=1 every cycle.
  - Lane k address: rd_addrk = base + (s*LANES+k)*COLS + c.
  - lane_mask bit k = ((s*LANES+k) < WIN). Example: WIN=7 gives 111, 111, 001.
  - Masked lane addresses are driven but ignored downstream.
  - On each consumed beat, c increments. When c=WIN-1, c wraps to 0 and s increments.
  - rd_last = (s=STRIPS-1 && c=WIN-1).
  - rd_ready=0 holds every address, mask and rd_last output stable; rd_en stays high.
  - After the beat with rd_last is consumed: win_done pulses in the next cycle, and the state returns to WAIT_PT.
- Latency: handshake cycle T -> CALC at T+1 -> first rd_en at T+2. With rd_ready held high, a window takes STRIPS*WIN beats (21 for WIN=7).
- frame_start during CALC/READ is ignored (no state change, frame_ready unchanged).
- Asynchronous reset in any state returns the block to IDLE with outputs 0 within the same cycle. The window in flight is discarded: no win_done pulse and no partial rd_last.
- busy = (state is LOAD, CALC or READ).
- Addresses are registered outputs. Read data returns from memory one cycle after a consumed beat; pairing data to lane_mask is the consumer's job.

Test Plan:
- Frame load: frame_start, then 1089 pix_valid cycles with random gaps -> wr_addr steps 0..1088 with no skips; frame_ready rises the cycle after the 1089th write; pt_ready=0 throughout.
- Center point (16,16), rd_ready=1 -> first beat at handshake+2 with addrs 442/475/508 and mask 111; strip-0 last beat addr0=448; strip 2 first beat addr0=640, mask 001; rd_last on beat 21; win_done one cycle later.
- Back-pressure: rd_ready low for 3 cycles at beat 5 of point (16,16) -> rd_addr0=446 and mask held for all 3 cycles; still 21 consumed beats total.
- Out-of-bounds point (2,16), then (16,30) -> err_oob pulse each time, zero rd_en, pt_ready high again 2 cycles after handshake.
- Collision: frame_start and pt_valid in the same WAIT_PT cycle -> point not accepted, state LOAD, frame_ready=0, wr_addr=0.
- Reset mid-READ at beat 10 -> all outputs 0 asynchronously, no win_done; a later frame_start restarts loading at wr_addr 0.
